// File: rtl/interconnect_pkg.sv
// Shared constants and helpers for the interconnect transmit path.
package interconnect_pkg;
  localparam int DEF_WIDTH    = 128;
  localparam int DEF_CHANNELS = 4;

  // Width of a channel index. A lone channel still needs one bit.
  function automatic int calc_cw(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant selection: the first requester found searching upward from rr_ptr+1, wrapping modulo N.
module rr_arbiter
  import interconnect_pkg::*;
#(
  parameter  int N  = DEF_CHANNELS,
  localparam int CW = calc_cw(N)
) (
  input  logic [N-1:0]  req,
  input  logic [CW-1:0] rr_ptr,
  output logic [N-1:0]  grant,
  output logic [CW-1:0] grant_idx,
  output logic          grant_vld
);

  logic [CW-1:0] cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    cand      = '0;
    // rr_ptr itself is visited last (k == N), so it wins only when it is the sole requester.
    for (int k = 1; k <= N; k++) begin
      cand = CW'((int'(rr_ptr) + k) % N);
      if (!grant_vld && req[cand]) begin
        grant_vld   = 1'b1;
        grant_idx   = cand;
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/interconnect_tx_arbiter.sv
// Merges CHANNELS valid/ready streams onto one link through a single output register.
// Define INTERCONNECT_TX_STATS_EN to add the saturating sent_count output.
module interconnect_tx_arbiter
  import interconnect_pkg::*;
#(
  parameter  int WIDTH    = DEF_WIDTH,
  parameter  int CHANNELS = DEF_CHANNELS,
  localparam int CW       = calc_cw(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [WIDTH*CHANNELS-1:0] ch_in_data,
  input  logic [CHANNELS-1:0]       ch_in_valid,
  output logic [CHANNELS-1:0]       ch_in_ready,
  output logic [WIDTH-1:0]          link_out_data,
  output logic [CW-1:0]             link_out_chan,
  output logic                      link_out_valid,
  input  logic                      link_out_ready,
  input  logic [CHANNELS-1:0]       ch_odd_clusters,
  output logic                      has_message_flying,
  output logic                      has_odd_clusters
`ifdef INTERCONNECT_TX_STATS_EN
  ,
  output logic [15:0]               sent_count
`endif
);

  logic [WIDTH-1:0]    ch_data [CHANNELS];
  logic [CHANNELS-1:0] grant;
  logic [CW-1:0]       grant_idx;
  logic                grant_vld;
  logic [CW-1:0]       rr_ptr;
  logic                out_free;
  logic                accept;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_split
    assign ch_data[i] = ch_in_data[i*WIDTH +: WIDTH];
  end

  rr_arbiter #(.N(CHANNELS)) u_rr (
    .req       (ch_in_valid),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  // Ready is gated by reset so no channel sees a handshake while reset is held.
  assign out_free    = !link_out_valid || link_out_ready;
  assign ch_in_ready = (out_free && reset) ? grant : '0;
  assign accept      = grant_vld && out_free && reset;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      link_out_valid <= 1'b0;
      link_out_data  <= '0;
      link_out_chan  <= '0;
      rr_ptr         <= CW'(CHANNELS - 1);
    end else if (accept) begin
      link_out_valid <= 1'b1;
      link_out_data  <= ch_data[grant_idx];
      link_out_chan  <= grant_idx;
      rr_ptr         <= grant_idx;
    end else if (link_out_ready) begin
      link_out_valid <= 1'b0;
    end
  end

  assign has_message_flying = (|ch_in_valid) || link_out_valid;
  assign has_odd_clusters   = |ch_odd_clusters;

`ifdef INTERCONNECT_TX_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      sent_count <= '0;
    else if (link_out_valid && link_out_ready && sent_count != 16'hFFFF)
      sent_count <= sent_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_interconnect_tx_arbiter.sv
// Directed bench for interconnect_tx_arbiter: cycle table plus hand sequences for stall, reset and stats.
module tb_interconnect_tx_arbiter;
  localparam int W  = 16;
  localparam int N  = 4;
  localparam int CW = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [W*N-1:0]  ch_in_data;
  logic [N-1:0]    ch_in_valid;
  logic [N-1:0]    ch_in_ready;
  logic [W-1:0]    link_out_data;
  logic [CW-1:0]   link_out_chan;
  logic            link_out_valid;
  logic            link_out_ready;
  logic [N-1:0]    ch_odd_clusters;
  logic            has_message_flying;
  logic            has_odd_clusters;
`ifdef INTERCONNECT_TX_STATS_EN
  logic [15:0]     sent_count;
`endif

  int total = 0;
  int bad   = 0;

  interconnect_tx_arbiter #(.WIDTH(W), .CHANNELS(N)) dut (
    .clk                (clk),
    .reset              (reset),
    .ch_in_data         (ch_in_data),
    .ch_in_valid        (ch_in_valid),
    .ch_in_ready        (ch_in_ready),
    .link_out_data      (link_out_data),
    .link_out_chan      (link_out_chan),
    .link_out_valid     (link_out_valid),
    .link_out_ready     (link_out_ready),
    .ch_odd_clusters    (ch_odd_clusters),
    .has_message_flying (has_message_flying),
    .has_odd_clusters   (has_odd_clusters)
`ifdef INTERCONNECT_TX_STATS_EN
    ,
    .sent_count         (sent_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  v;
    logic [3:0]  odd;
    logic        lr;
    logic [3:0]  er;
    logic        ev;
    logic [1:0]  ec;
    logic [15:0] ed;
    logic        ef;
    logic        eo;
  } vec_t;

  vec_t tbl [18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(logic [3:0] v, logic [3:0] odd, logic lr, logic [3:0] er,
                              logic ev, logic [1:0] ec, logic [15:0] ed, logic ef, logic eo);
    vec_t r;
    r.v = v; r.odd = odd; r.lr = lr; r.er = er; r.ev = ev;
    r.ec = ec; r.ed = ed; r.ef = ef; r.eo = eo;
    return r;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit seen;
    // Expected values assume rr_ptr starts at 3 and each channel carries 16'hA000+i.
    tbl[0]  = mk(4'b1111, 4'b0000, 1'b1, 4'b0001, 1'b0, 2'd0, 16'h0000, 1'b1, 1'b0);
    tbl[1]  = mk(4'b1111, 4'b0000, 1'b1, 4'b0010, 1'b1, 2'd0, 16'hA000, 1'b1, 1'b0);
    tbl[2]  = mk(4'b1111, 4'b0000, 1'b1, 4'b0100, 1'b1, 2'd1, 16'hA001, 1'b1, 1'b0);
    tbl[3]  = mk(4'b1111, 4'b0000, 1'b1, 4'b1000, 1'b1, 2'd2, 16'hA002, 1'b1, 1'b0);
    tbl[4]  = mk(4'b1111, 4'b0000, 1'b1, 4'b0001, 1'b1, 2'd3, 16'hA003, 1'b1, 1'b0);
    for (int i = 5; i <= 9; i++)
      tbl[i] = mk(4'b1111, 4'b0000, 1'b0, 4'b0000, 1'b1, 2'd0, 16'hA000, 1'b1, 1'b0);
    tbl[10] = mk(4'b1111, 4'b0000, 1'b1, 4'b0010, 1'b1, 2'd0, 16'hA000, 1'b1, 1'b0);
    tbl[11] = mk(4'b0000, 4'b0100, 1'b1, 4'b0000, 1'b1, 2'd1, 16'hA001, 1'b1, 1'b1);
    tbl[12] = mk(4'b0000, 4'b0100, 1'b1, 4'b0000, 1'b0, 2'd1, 16'hA001, 1'b0, 1'b1);
    tbl[13] = mk(4'b0101, 4'b0000, 1'b0, 4'b0100, 1'b0, 2'd1, 16'hA001, 1'b1, 1'b0);
    tbl[14] = mk(4'b0101, 4'b0000, 1'b0, 4'b0000, 1'b1, 2'd2, 16'hA002, 1'b1, 1'b0);
    tbl[15] = mk(4'b0101, 4'b0000, 1'b1, 4'b0001, 1'b1, 2'd2, 16'hA002, 1'b1, 1'b0);
    tbl[16] = mk(4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'd0, 16'hA000, 1'b1, 1'b0);
    tbl[17] = mk(4'b0000, 4'b1000, 1'b0, 4'b0000, 1'b0, 2'd0, 16'hA000, 1'b0, 1'b1);

    reset = 1'b0;
    ch_in_valid = 4'b1111;
    link_out_ready = 1'b1;
    ch_odd_clusters = '0;
    for (int i = 0; i < N; i++) ch_in_data[i*W +: W] = 16'hA000 + 16'(i);

    // Reset state, with all channels requesting.
    repeat (3) @(negedge clk);
    #1;
    check("rst_valid", 32'(link_out_valid), 32'd0);
    check("rst_data",  32'(link_out_data),  32'd0);
    check("rst_chan",  32'(link_out_chan),  32'd0);
    check("rst_ready", 32'(ch_in_ready),    32'd0);

    // Cycle table starting from the first cycle after release.
    for (int s = 0; s < 18; s++) begin
      @(negedge clk);
      reset = 1'b1;
      ch_in_valid = tbl[s].v;
      ch_odd_clusters = tbl[s].odd;
      link_out_ready = tbl[s].lr;
      #1;
      check($sformatf("t%0d_ready", s), 32'(ch_in_ready),        32'(tbl[s].er));
      check($sformatf("t%0d_valid", s), 32'(link_out_valid),     32'(tbl[s].ev));
      check($sformatf("t%0d_chan",  s), 32'(link_out_chan),      32'(tbl[s].ec));
      check($sformatf("t%0d_data",  s), 32'(link_out_data),      32'(tbl[s].ed));
      check($sformatf("t%0d_fly",   s), 32'(has_message_flying), 32'(tbl[s].ef));
      check($sformatf("t%0d_odd",   s), 32'(has_odd_clusters),   32'(tbl[s].eo));
    end

    // Only channel 2 streams three messages back to back; rr_ptr is 0 here.
    ch_odd_clusters = '0;
    link_out_ready = 1'b1;
    for (int m = 0; m < 3; m++) begin
      @(negedge clk);
      ch_in_valid = 4'b0100;
      ch_in_data[2*W +: W] = 16'hB000 + 16'(m);
      #1;
      check($sformatf("c2_ready%0d", m), 32'(ch_in_ready), 32'b0100);
      if (m > 0) begin
        check($sformatf("c2_valid%0d", m), 32'(link_out_valid), 32'd1);
        check($sformatf("c2_chan%0d",  m), 32'(link_out_chan),  32'd2);
        check($sformatf("c2_data%0d",  m), 32'(link_out_data),  32'(16'hB000 + 16'(m - 1)));
      end
    end
    @(negedge clk);
    ch_in_valid = '0;
    #1;
    check("c2_last_valid", 32'(link_out_valid), 32'd1);
    check("c2_last_data",  32'(link_out_data),  32'hB002);
    @(negedge clk);
    #1;
    check("c2_drain", 32'(link_out_valid), 32'd0);

    // Reset asserted while a message is held on a stalled link.
    ch_in_data[0 +: W] = 16'hC000;
    ch_in_valid = 4'b0001;
    link_out_ready = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 8 && !seen; c++) begin
      @(negedge clk);
      #1;
      seen = link_out_valid;
    end
    check("rst_mid_loaded", 32'(seen), 32'd1);
    ch_in_valid = '0;
    #2 reset = 1'b0;
    #1;
    check("rst_mid_valid", 32'(link_out_valid), 32'd0);
    check("rst_mid_data",  32'(link_out_data),  32'd0);
    check("rst_mid_ready", 32'(ch_in_ready),    32'd0);
    check("rst_mid_fly",   32'(has_message_flying), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    ch_in_valid = 4'b0011;
    link_out_ready = 1'b1;
    #1;
    check("rel_no_replay", 32'(link_out_valid),     32'd0);
    check("rel_fly",       32'(has_message_flying), 32'd1);
    check("rel_grant0",    32'(ch_in_ready),        32'b0001);
    @(negedge clk);
    ch_in_valid = '0;
    #1;
    check("rel_chan", 32'(link_out_chan), 32'd0);
    check("rel_data", 32'(link_out_data), 32'hC000);

`ifdef INTERCONNECT_TX_STATS_EN
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("cnt_reset", 32'(sent_count), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    ch_in_valid = 4'b0001;
    link_out_ready = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    check("cnt_nine", 32'(sent_count), 32'd9);
    repeat (70000) @(negedge clk);
    #1;
    check("cnt_sat", 32'(sent_count), 32'hFFFF);
    repeat (5) @(negedge clk);
    #1;
    check("cnt_hold", 32'(sent_count), 32'hFFFF);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/interconnect_tx_arbiter.md
INTERCONNECT_TX_ARBITER -- requirements
Module: interconnect_tx_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 128, payload bits per channel message.
REQ-002 SHALL have parameter CHANNELS, default 4, number of input channels; legal range is 2..16.
REQ-003 SHALL have port clk, input, 1 bit; the single clock.
REQ-004 SHALL have port reset, input, 1 bit; asynchronous, active-low reset.
REQ-005 SHALL have port ch_in_data, input, WIDTH*CHANNELS bits; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-006 SHALL have port ch_in_valid, input, CHANNELS bits; per-channel valid.
REQ-007 SHALL have port ch_in_ready, output, CHANNELS bits; per-channel ready.
REQ-008 SHALL have port link_out_data, output, WIDTH bits; serialized payload.
REQ-009 SHALL have port link_out_chan, output, CW = $clog2(CHANNELS) bits; source channel index.
REQ-010 SHALL have ports link_out_valid (output, 1 bit) and link_out_ready (input, 1 bit); link handshake.
REQ-011 SHALL have port ch_odd_clusters, input, CHANNELS bits; per-channel odd-cluster status.
REQ-012 SHALL have ports has_message_flying and has_odd_clusters, each an output of 1 bit; aggregated status.

Function
REQ-013 SHALL transfer on a channel when ch_in_valid[i] && ch_in_ready[i], and on the link when link_out_valid && link_out_ready.
REQ-014 SHALL hold exactly one output register (data, chan, valid); the register is free when !link_out_valid || link_out_ready.
REQ-015 SHALL assert at most one ch_in_ready bit per cycle: only the granted channel, and only while the output register is free.
REQ-016 SHALL choose the grant round-robin: the first valid channel searching upward from rr_ptr+1 modulo CHANNELS.
REQ-017 SHALL, on an input transfer from channel g, load the output register next cycle and set rr_ptr to g, giving 1-cycle latency from accept to link_out_valid.
REQ-018 SHALL accept a new message in the same cycle the link consumes the previous one, sustaining 1 message/cycle.
REQ-019 SHALL hold link_out_data and link_out_chan stable while link_out_valid && !link_out_ready.
REQ-020 SHALL clear link_out_valid after a link transfer when no input transfer occurs in that cycle.
REQ-021 SHALL leave rr_ptr unchanged when no channel is valid.
REQ-022 SHALL drive has_message_flying combinationally as |ch_in_valid || link_out_valid.
REQ-023 SHALL drive has_odd_clusters combinationally as |ch_odd_clusters.

Reset
REQ-024 SHALL, while reset is low, force link_out_valid=0, link_out_data=0, link_out_chan=0, rr_ptr=CHANNELS-1 (so channel 0 is first), and ch_in_ready=0.
REQ-025 SHALL discard a message held in the output register when reset asserts mid-transfer; the message is not replayed.
REQ-026 SHALL grant channel 0 first in the first cycle after reset deasserts if channel 0 is valid.

Configuration
REQ-027 SHALL, when macro INTERCONNECT_TX_STATS_EN is defined, add output sent_count (16 bits), incremented on each link transfer, saturating at 0xFFFF, and reset to 0.
REQ-028 SHALL, without INTERCONNECT_TX_STATS_EN, omit the sent_count port and its logic; all other behaviour is identical.

Structure
REQ-029 SHALL place the CW computation function and the default WIDTH/CHANNELS constants in shared package interconnect_pkg.
REQ-030 SHALL implement grant selection in sub-module rr_arbiter (inputs: request vector and rr_ptr; output: one-hot grant and index).

Verification
REQ-031 SHALL cover reset release with ch_in_valid=4'b1111 and link_out_ready=1: grants are 0,1,2,3,0 on consecutive cycles, and link_out_chan follows one cycle later.
REQ-032 SHALL cover link_out_ready=0 for 5 cycles with link_out_valid=1: data and chan stay stable, ch_in_ready=0, and no input is lost.
REQ-033 SHALL cover only channel 2 valid for 3 messages with ready=1: 3 back-to-back link transfers with chan=2 and unchanged payload order.
REQ-034 SHALL cover reset asserted while link_out_valid=1: link_out_valid drops asynchronously, and after release has_message_flying = |ch_in_valid.
REQ-035 SHALL cover ch_odd_clusters=4'b0100 with all valid low: has_odd_clusters=1 and has_message_flying=0.
REQ-036 SHALL, with INTERCONNECT_TX_STATS_EN, cover 70000 transfers: sent_count=0xFFFF and it stays there.
